// File: rtl/demux_1x2_buffered_seq_if.sv
// Handshake bundle between an upstream source, the 1-to-2 demux and its two downstream sinks.
// The slave modport is the demux's view; the master modport drives it.
interface demux_1x2_buffered_seq_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int COMMAND_WIDTH = 2
);
    logic                     i_valid;
    logic [DATA_WIDTH-1:0]    i_data_bus;
    logic [COMMAND_WIDTH-1:0] i_cmd;
    logic                     i_en;
    logic                     o_ready;
    logic [1:0]               o_valid;
    logic [2*DATA_WIDTH-1:0]  o_data_bus;
    logic [1:0]               i_ready;

    modport slave (
        input  i_valid, i_data_bus, i_cmd, i_en, i_ready,
        output o_ready, o_valid, o_data_bus
    );

    modport master (
        output i_valid, i_data_bus, i_cmd, i_en, i_ready,
        input  o_ready, o_valid, o_data_bus
    );
endinterface

// File: rtl/demux_1x2_buffered_seq.sv
// 1-to-2 distributor: routes each word to low/high/both/none into per-branch FIFOs.
// Latency 1 cycle; o_ready drops when any selected branch FIFO is full (multicast all-or-nothing).
module demux_1x2_buffered_seq #(
    parameter int DATA_WIDTH    = 32,
    parameter int COMMAND_WIDTH = 2,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    demux_1x2_buffered_seq_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [COMMAND_WIDTH-1:0] cmd;
    logic [1:0]               full;
    logic [1:0]               empty;
    logic [1:0]               push;
    logic [1:0]               pop;
    logic                     accept;
    logic [DATA_WIDTH-1:0]    head [2];

    assign cmd = bus.i_cmd;

    // Any selected branch being full blocks the whole word, even if it pops this cycle.
    assign bus.o_ready = bus.i_en & ~|(cmd[1:0] & full);
    assign accept      = bus.i_valid & bus.o_ready;
    assign push        = accept ? cmd[1:0] : 2'b00;
    assign pop         = ~empty & bus.i_ready;

    for (genvar b = 0; b < 2; b++) begin : g_branch
        logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
        logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
        logic [CNT_W-1:0]      count_q, count_d;

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            count_d  = count_q;
            if (push[b]) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop[b])  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push[b], pop[b]})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
            end
        end

        // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
        always_ff @(posedge clk) begin
            if (!rst && push[b]) mem_q[wr_ptr_q] <= bus.i_data_bus;
        end

        assign full[b]  = (count_q == CNT_W'(FIFO_DEPTH));
        assign empty[b] = (count_q == '0);
        assign head[b]  = empty[b] ? '0 : mem_q[rd_ptr_q];
    end

    assign bus.o_valid    = ~empty;
    assign bus.o_data_bus = {head[1], head[0]};
endmodule

// File: tb/tb_demux_1x2_buffered_seq.sv
// Directed bench for the 1-to-2 buffered demux with a queue-based scoreboard per branch.
module tb_demux_1x2_buffered_seq;
    localparam int DW = 32;

    logic clk;
    logic rst;
    logic mon_en;
    int   vectors;
    int   miscompares;
    logic [DW-1:0] q_lo[$];
    logic [DW-1:0] q_hi[$];

    demux_1x2_buffered_seq_if #(.DATA_WIDTH(DW), .COMMAND_WIDTH(2)) bus ();

    demux_1x2_buffered_seq #(.DATA_WIDTH(DW), .COMMAND_WIDTH(2), .FIFO_DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever a branch transfers downstream.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            for (int b = 0; b < 2; b++) begin
                logic [DW-1:0] act;
                logic [DW-1:0] exp;
                act = bus.o_data_bus[b*DW +: DW];
                if (!bus.o_valid[b]) begin
                    check($sformatf("idle_data_b%0d", b), 64'(act), 64'd0);
                end else if (bus.i_ready[b]) begin
                    if (b == 0 && q_lo.size() > 0) begin
                        exp = q_lo.pop_front();
                        check("lo_data", 64'(act), 64'(exp));
                    end else if (b == 1 && q_hi.size() > 0) begin
                        exp = q_hi.pop_front();
                        check("hi_data", 64'(act), 64'(exp));
                    end else begin
                        check($sformatf("unexpected_valid_b%0d", b), 64'(bus.o_valid[b]), 64'd0);
                    end
                end
            end
        end
    end

    // One input cycle: drive, check o_ready (and optionally o_valid) mid-cycle, record accepted word.
    task automatic drive(input string name, input logic v, input logic [DW-1:0] d,
                         input logic [1:0] cmd, input logic en, input logic [1:0] rdy,
                         input logic exp_rdy, input logic chk_v, input logic [1:0] exp_v);
        bus.i_valid    = v;
        bus.i_data_bus = d;
        bus.i_cmd      = cmd;
        bus.i_en       = en;
        bus.i_ready    = rdy;
        @(negedge clk);
        check({name, "_ordy"}, 64'(bus.o_ready), 64'(exp_rdy));
        if (chk_v) check({name, "_ovld"}, 64'(bus.o_valid), 64'(exp_v));
        @(posedge clk);
        if (v && exp_rdy) begin
            if (cmd[0]) q_lo.push_back(d);
            if (cmd[1]) q_hi.push_back(d);
        end
        #1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        mon_en = 1'b0;
        rst = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_data_bus = '0;
        bus.i_cmd = 2'b00;
        bus.i_en = 1'b1;
        bus.i_ready = 2'b11;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mon_en = 1'b1;
        drive("idle_en1", 0, 32'h0, 2'b00, 1, 2'b11, 1, 1, 2'b00);
        check("idle_data", bus.o_data_bus, 64'd0);
        drive("idle_en0", 0, 32'h0, 2'b00, 0, 2'b11, 0, 1, 2'b00);

        // Unicast routing, one-cycle latency, one-cycle valid each
        drive("uni_a5", 1, 32'hA5, 2'b01, 1, 2'b11, 1, 1, 2'b00);
        drive("uni_3c", 1, 32'h3C, 2'b10, 1, 2'b11, 1, 1, 2'b01);
        drive("uni_w1", 0, 32'h0,  2'b00, 1, 2'b11, 1, 1, 2'b10);
        drive("uni_w2", 0, 32'h0,  2'b00, 1, 2'b11, 1, 1, 2'b00);

        // Backpressure on low branch, no bypass on a full FIFO
        drive("bp_1",   1, 32'h1, 2'b01, 1, 2'b10, 1, 1, 2'b00);
        drive("bp_2",   1, 32'h2, 2'b01, 1, 2'b10, 1, 1, 2'b01);
        drive("bp_3a",  1, 32'h3, 2'b01, 1, 2'b10, 0, 1, 2'b01);
        drive("bp_3b",  1, 32'h3, 2'b01, 1, 2'b10, 0, 1, 2'b01);
        drive("bp_3c",  1, 32'h3, 2'b01, 1, 2'b11, 0, 1, 2'b01);
        drive("bp_3d",  1, 32'h3, 2'b01, 1, 2'b11, 1, 1, 2'b01);
        drive("bp_w1",  0, 32'h0, 2'b00, 1, 2'b11, 1, 1, 2'b01);
        drive("bp_w2",  0, 32'h0, 2'b00, 1, 2'b11, 1, 1, 2'b00);

        // Multicast blocked by a full high FIFO, then lands in both at once
        drive("mc_10",  1, 32'h10, 2'b10, 1, 2'b01, 1, 1, 2'b00);
        drive("mc_11",  1, 32'h11, 2'b10, 1, 2'b01, 1, 1, 2'b10);
        drive("mc_77a", 1, 32'h77, 2'b11, 1, 2'b01, 0, 1, 2'b10);
        drive("mc_77b", 1, 32'h77, 2'b11, 1, 2'b01, 0, 1, 2'b10);
        drive("mc_77c", 1, 32'h77, 2'b11, 1, 2'b11, 0, 1, 2'b10);
        drive("mc_77d", 1, 32'h77, 2'b11, 1, 2'b11, 1, 1, 2'b10);
        drive("mc_w1",  0, 32'h0,  2'b00, 1, 2'b11, 1, 1, 2'b11);
        drive("mc_w2",  0, 32'h0,  2'b00, 1, 2'b11, 1, 1, 2'b00);

        // Drop command consumes the word without output
        drive("drop_55", 1, 32'h55, 2'b00, 1, 2'b11, 1, 1, 2'b00);
        drive("drop_w1", 0, 32'h0,  2'b00, 1, 2'b11, 1, 1, 2'b00);
        drive("drop_w2", 0, 32'h0,  2'b00, 1, 2'b11, 1, 1, 2'b00);

        // Disable blocks acceptance while buffered words still drain
        drive("dis_b1", 1, 32'hB1, 2'b01, 1, 2'b00, 1, 1, 2'b00);
        drive("dis_b2", 1, 32'hB2, 2'b10, 1, 2'b00, 1, 1, 2'b01);
        drive("dis_ee", 1, 32'hEE, 2'b01, 0, 2'b00, 0, 1, 2'b11);
        drive("dis_dr", 1, 32'hEE, 2'b11, 0, 2'b11, 0, 1, 2'b11);
        drive("dis_w1", 0, 32'h0,  2'b00, 0, 2'b11, 0, 1, 2'b00);

        // Reset mid-operation with an input offered
        drive("rs_c1", 1, 32'hC1, 2'b11, 1, 2'b00, 1, 1, 2'b00);
        drive("rs_c2", 1, 32'hC2, 2'b01, 1, 2'b00, 1, 1, 2'b11);
        rst = 1'b1;
        bus.i_valid = 1'b1;
        bus.i_data_bus = 32'hDD;
        bus.i_cmd = 2'b11;
        bus.i_en = 1'b1;
        @(posedge clk);
        q_lo.delete();
        q_hi.delete();
        #1;
        rst = 1'b0;
        drive("rs_w1", 0, 32'h0, 2'b00, 1, 2'b11, 1, 1, 2'b00);
        check("rs_data", bus.o_data_bus, 64'd0);
        drive("rs_w2", 0, 32'h0, 2'b00, 1, 2'b11, 1, 1, 2'b00);

        check("lo_queue_left", 64'(q_lo.size()), 64'd0);
        check("hi_queue_left", 64'(q_hi.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
